// File: rtl/carbon1_reset_seq.sv
// Board reset sequencer: pulses the SPI flash reset, waits for flash ready, holds the SoC
// in reset, then releases it. A debounced button press or a software request restarts it.
module carbon1_reset_seq #(
  parameter int FLASH_RST_CYCLES  = 100,
  parameter int FLASH_WAIT_CYCLES = 3000,
  parameter int SYS_HOLD_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic       io_clock,
  input  logic       io_reset,
  input  logic       io_button,
  input  logic       io_swReset,
  output logic       io_sysReset_out,
  output logic       io_spi0_rst,
  output logic       io_resetDone,
  output logic [1:0] io_state
);

  typedef enum logic [1:0] {
    FLASH_RST  = 2'd0,
    FLASH_WAIT = 2'd1,
    SYS_RST    = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam int CNT_MAX_A = (FLASH_RST_CYCLES > FLASH_WAIT_CYCLES) ? FLASH_RST_CYCLES
                                                                     : FLASH_WAIT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > SYS_HOLD_CYCLES) ? CNT_MAX_A : SYS_HOLD_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CNT_W-1:0] FR_LAST = CNT_W'(FLASH_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FW_LAST = CNT_W'(FLASH_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SH_LAST = CNT_W'(SYS_HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Raw pin level when the button is not pressed
  localparam logic BTN_IDLE = (BUTTON_ACTIVE_LOW != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             btn_meta;
  logic             btn_sync;
  logic             pressed;
  logic             btn_deb;
  logic [DB_W-1:0]  db_cnt;
  logic             db_flip;
  logic             restart;

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      btn_meta <= BTN_IDLE;
      btn_sync <= BTN_IDLE;
    end else begin
      btn_meta <= io_button;
      btn_sync <= btn_meta;
    end
  end

  assign pressed = btn_sync ^ BTN_IDLE;
  assign db_flip = (pressed != btn_deb) && (db_cnt == DB_LAST);

  // Only the press edge restarts; a held button or its release does nothing further
  assign restart = (db_flip && pressed) || io_swReset;

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      btn_deb <= 1'b0;
      db_cnt  <= '0;
    end else if (pressed != btn_deb) begin
      if (db_flip) begin
        btn_deb <= pressed;
        db_cnt  <= '0;
      end else begin
        db_cnt  <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge io_clock) begin
    if (io_reset || restart) begin
      state <= FLASH_RST;
      cnt   <= '0;
    end else begin
      unique case (state)
        FLASH_RST: begin
          if (cnt == FR_LAST) begin
            state <= FLASH_WAIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FLASH_WAIT: begin
          if (cnt == FW_LAST) begin
            state <= SYS_RST;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SYS_RST: begin
          if (cnt == SH_LAST) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt <= '0;
        end
        default: begin
          state <= FLASH_RST;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign io_spi0_rst     = (state != FLASH_RST);
  assign io_sysReset_out = (state != RUN);
  assign io_resetDone    = (state == RUN);
  assign io_state        = state;

endmodule

// File: tb/tb_carbon1_reset_seq.sv
// Directed bench for carbon1_reset_seq with short timing parameters.
module tb_carbon1_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b1;
  logic       sw  = 1'b0;
  logic       sys_rst;
  logic       spi_rst;
  logic       done;
  logic [1:0] st;

  int n_vec  = 0;
  int n_fail = 0;

  carbon1_reset_seq #(
    .FLASH_RST_CYCLES (4),
    .FLASH_WAIT_CYCLES(6),
    .SYS_HOLD_CYCLES  (3),
    .DEBOUNCE_CYCLES  (5),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .io_clock       (clk),
    .io_reset       (rst),
    .io_button      (btn),
    .io_swReset     (sw),
    .io_sysReset_out(sys_rst),
    .io_spi0_rst    (spi_rst),
    .io_resetDone   (done),
    .io_state       (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       sw;
    logic [1:0] st;
    logic       spi;
    logic       sys;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic b, input logic s, input logic [1:0] e_st,
                     input logic e_spi, input logic e_sys, input logic e_done);
    vec_t v;
    v.rst = r; v.btn = b; v.sw = s;
    v.st = e_st; v.spi = e_spi; v.sys = e_sys; v.done = e_done;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare all outputs against the decode of an expected state
  task automatic chk_state(input string tag, input logic [1:0] e_st);
    chk({tag, ".state"}, 32'(st), 32'(e_st));
    chk({tag, ".spi0_rst"}, 32'(spi_rst), 32'(e_st != 2'd0));
    chk({tag, ".sysReset"}, 32'(sys_rst), 32'(e_st != 2'd3));
    chk({tag, ".resetDone"}, 32'(done), 32'(e_st == 2'd3));
  endtask

  function automatic logic [1:0] seq_state(input int c);
    if (c < 4) return 2'd0;
    if (c < 10) return 2'd1;
    if (c < 13) return 2'd2;
    return 2'd3;
  endfunction

  // Called in cycle 0 of a fresh sequence; walks cycles 1..last
  task automatic run_seq(input string tag, input int last);
    for (int c = 1; c <= last; c++) begin
      step();
      chk_state($sformatf("%s.c%0d", tag, c), seq_state(c));
    end
  endtask

  initial begin
    int lat;
    int held;

    // Reset held 3 edges (swReset asserted meanwhile must be ignored), then power-up sequence
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) add(0, 1, 0, 0, 0, 1, 0);
    for (int i = 4; i <= 9; i++) add(0, 1, 0, 1, 1, 1, 0);
    for (int i = 10; i <= 12; i++) add(0, 1, 0, 2, 1, 1, 0);
    for (int i = 13; i <= 15; i++) add(0, 1, 0, 3, 1, 0, 1);
    // 4-cycle glitch is one short of the debounce window
    for (int i = 0; i < 4; i++) add(0, 0, 0, 3, 1, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 3, 1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      sw  = tbl[i].sw;
      step();
      chk($sformatf("vec%0d.state", i), 32'(st), 32'(tbl[i].st));
      chk($sformatf("vec%0d.spi0_rst", i), 32'(spi_rst), 32'(tbl[i].spi));
      chk($sformatf("vec%0d.sysReset", i), 32'(sys_rst), 32'(tbl[i].sys));
      chk($sformatf("vec%0d.resetDone", i), 32'(done), 32'(tbl[i].done));
    end
    sw = 1'b0;

    // Held press: 2 sync + 5 debounce edges to restart, then one full sequence only
    btn = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      step();
      if (st == 2'd0) lat = k;
    end
    n_vec++;
    if (lat < 7 || lat > 8) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles (0 = none) expected 7..8", lat);
    end
    chk_state("press.c0", 2'd0);
    run_seq("press", 13);
    held = lat + 13;
    while (held < 40) begin
      step();
      held++;
      chk_state($sformatf("press_hold.%0d", held), 2'd3);
    end
    btn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk_state($sformatf("release.%0d", k), 2'd3);
    end

    // Software reset from RUN, then again during FLASH_WAIT with counter at 3
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk_state("sw_run.c0", 2'd0);
    run_seq("sw_pre", 7);
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk_state("sw_wait.c0", 2'd0);
    run_seq("sw_wait", 13);

    // io_reset in SYS_RST with a simultaneous swReset
    sw = 1'b1;
    step();
    sw = 1'b0;
    run_seq("pre_rst", 11);
    rst = 1'b1;
    sw  = 1'b1;
    step();
    rst = 1'b0;
    sw  = 1'b0;
    chk_state("mid_rst", 2'd0);
    run_seq("post_rst", 13);

    // swReset in the last SYS_RST cycle wins over the move to RUN
    sw = 1'b1;
    step();
    sw = 1'b0;
    run_seq("pre_sim", 12);
    sw = 1'b1;
    step();
    sw = 1'b0;
    chk_state("simul.c0", 2'd0);
    run_seq("simul", 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
